dc_mem_ctrl: RTL

//  Sequences D-cache miss, evict and uncached IO requests onto the 32-bit system memory bus.

---
 rtl/dc_pkg.sv | 32 +++
 rtl/dc_line_beat_mux.sv | 19 +
 rtl/dc_mem_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dc_pkg.sv
// Shared types and sizing for the D-cache memory controller: FSM states, op types,
// line/bus geometry and the per-beat address helper.
package dc_pkg;

   localparam int LINE_W = 128;
   localparam int BUS_W  = 32;
   localparam int BEATS  = LINE_W / BUS_W;
   localparam int BEAT_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_EVICT,
      ST_FILL,
      ST_MACK,
      ST_IO,
      ST_IOACK,
      ST_RECOV
   } state_e;

   typedef enum logic {
      OP_MISS = 1'b0,
      OP_IO   = 1'b1
   } op_e;

   // Word address of a beat within a line-aligned base; no carry reaches [31:4].
   function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                             input logic [BEAT_W-1:0] beat);
      return base + {{(32-BEAT_W-2){1'b0}}, beat, 2'b00};
   endfunction

endpackage

// File: rtl/dc_line_beat_mux.sv
// Selects the current 32-bit write-back word out of the victim line and decodes the
// one-hot word write-enable used to assemble the fill line.
module dc_line_beat_mux
   import dc_pkg::*;
(
   input  logic [LINE_W-1:0] line,
   input  logic [BEAT_W-1:0] beat,
   input  logic              fill_en,
   output logic [BUS_W-1:0]  beat_word,
   output logic [BEATS-1:0]  fill_we
);

   always_comb begin
      beat_word     = line[BUS_W*beat +: BUS_W];
      fill_we       = '0;
      fill_we[beat] = fill_en;
   end

endmodule

// File: rtl/dc_mem_ctrl.sv
// Sequences dcache line write-back/fill and uncached IO accesses onto the 32-bit system bus.
// A miss is one bus tenure: optional 4 write beats, then 4 read beats, then a one-cycle ack.
module dc_mem_ctrl
   import dc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dc_miss,
   input  logic [31:0]       dc_miss_addr,
   input  logic              dc_evict,
   input  logic [31:0]       dc_evict_addr,
   input  logic [LINE_W-1:0] dc_evict_data,
   output logic [LINE_W-1:0] dc_data_fill,
   output logic              dc_miss_ack,
   input  logic              io_access,
   input  logic              io_rw,
   input  logic [31:0]       io_addr,
   input  logic [31:0]       io_wr_data,
   output logic [31:0]       io_rd_data,
   output logic              io_ack,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [31:0]       bus_addr,
   output logic              bus_wr,
   output logic              bus_vld,
   output logic [BUS_W-1:0]  bus_wdata,
   input  logic [BUS_W-1:0]  bus_rdata,
   input  logic              bus_ack
);

   state_e            state, state_nxt;
   op_e               op;
   logic [BEAT_W-1:0] beat;
   logic [LINE_W-1:0] fill_reg, fill_nxt;
   logic [BUS_W-1:0]  evict_word;
   logic [BEATS-1:0]  fill_we;
   logic              fill_en, beat_clr, beat_inc, io_rd_en, last_beat;

   assign last_beat = (beat == BEAT_W'(BEATS-1));

   dc_line_beat_mux u_beat_mux (
      .line      (dc_evict_data),
      .beat      (beat),
      .fill_en   (fill_en),
      .beat_word (evict_word),
      .fill_we   (fill_we)
   );

   always_comb begin
      state_nxt   = state;
      bus_req     = 1'b0;
      bus_vld     = 1'b0;
      bus_wr      = 1'b0;
      bus_addr    = '0;
      bus_wdata   = '0;
      dc_miss_ack = 1'b0;
      io_ack      = 1'b0;
      fill_en     = 1'b0;
      beat_clr    = 1'b0;
      beat_inc    = 1'b0;
      io_rd_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (io_access || dc_miss) state_nxt = ST_ARB;
         end
         ST_ARB: begin
            bus_req = 1'b1;
            if (bus_gnt) begin
               beat_clr = 1'b1;
               if (op == OP_IO)    state_nxt = ST_IO;
               else if (dc_evict)  state_nxt = ST_EVICT;
               else                state_nxt = ST_FILL;
            end
         end
         ST_EVICT: begin
            bus_req   = 1'b1;
            bus_vld   = 1'b1;
            bus_wr    = 1'b1;
            bus_addr  = beat_addr(dc_evict_addr, beat);
            bus_wdata = evict_word;
            // The beat counter wraps to 0 here, so the fill starts at word 0 without re-arbitrating.
            if (bus_ack) begin
               beat_inc = 1'b1;
               if (last_beat) state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            bus_req  = 1'b1;
            bus_vld  = 1'b1;
            bus_addr = beat_addr(dc_miss_addr, beat);
            if (bus_ack) begin
               fill_en  = 1'b1;
               beat_inc = 1'b1;
               if (last_beat) state_nxt = ST_MACK;
            end
         end
         ST_MACK: begin
            dc_miss_ack = 1'b1;
            state_nxt   = ST_RECOV;
         end
         ST_IO: begin
            bus_req   = 1'b1;
            bus_vld   = 1'b1;
            bus_wr    = io_rw;
            bus_addr  = io_addr;
            bus_wdata = io_wr_data;
            if (bus_ack) begin
               io_rd_en  = !io_rw;
               state_nxt = ST_IOACK;
            end
         end
         ST_IOACK: begin
            io_ack    = 1'b1;
            state_nxt = ST_RECOV;
         end
         // Gives the requester a cycle to drop its level request before IDLE samples it again.
         ST_RECOV: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      fill_nxt = fill_reg;
      for (int i = 0; i < BEATS; i++) begin
         if (fill_we[i]) fill_nxt[i*BUS_W +: BUS_W] = bus_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         op           <= OP_MISS;
         beat         <= '0;
         fill_reg     <= '0;
         dc_data_fill <= '0;
         io_rd_data   <= '0;
      end else begin
         state    <= state_nxt;
         fill_reg <= fill_nxt;
         // IO has priority when both requests are raised together; the miss waits in place.
         if (state == ST_IDLE) op <= io_access ? OP_IO : OP_MISS;
         if (beat_clr)      beat <= '0;
         else if (beat_inc) beat <= beat + 1'b1;
         if (fill_en && last_beat) dc_data_fill <= fill_nxt;
         if (io_rd_en)             io_rd_data   <= bus_rdata;
      end
   end

endmodule
